// File: rtl/i_fetch_group_buf_if.sv
// Bundle of the core-side fetch handshake and the SRAM-like instruction bus
// seen by i_fetch_group_buf.
//   slave  : the fetch buffer (drives requests to the bus, groups to the core)
//   master : the environment (core fetch stage + instruction bus)
// Signals:
//   fetch_en/fetch_addr/fetch_ready/flush          core request side
//   grp_valid/grp_addr/grp_rdata/grp_ok/grp_ready  buffered group to the core
//   i_stall                                        core waiting on empty buffer
//   inst_req/wr/size/addr/wdata                    bus request
//   inst_addr_ok/inst_data_ok/inst_rdata           bus handshake and response
interface i_fetch_group_buf_if #(
    parameter int NW = 2
);
    logic              fetch_en;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              flush;
    logic              grp_valid;
    logic [31:0]       grp_addr;
    logic [32*NW-1:0]  grp_rdata;
    logic [NW-1:0]     grp_ok;
    logic              grp_ready;
    logic              i_stall;
    logic              inst_req;
    logic              inst_wr;
    logic [1:0]        inst_size;
    logic [31:0]       inst_addr;
    logic [31:0]       inst_wdata;
    logic              inst_addr_ok;
    logic [NW-1:0]     inst_data_ok;
    logic [32*NW-1:0]  inst_rdata;

    modport slave (
        input  fetch_en, fetch_addr, flush, grp_ready,
               inst_addr_ok, inst_data_ok, inst_rdata,
        output fetch_ready, grp_valid, grp_addr, grp_rdata, grp_ok, i_stall,
               inst_req, inst_wr, inst_size, inst_addr, inst_wdata
    );

    modport master (
        output fetch_en, fetch_addr, flush, grp_ready,
               inst_addr_ok, inst_data_ok, inst_rdata,
        input  fetch_ready, grp_valid, grp_addr, grp_rdata, grp_ok, i_stall,
               inst_req, inst_wr, inst_size, inst_addr, inst_wdata
    );
endinterface

// File: rtl/i_fetch_group_buf.sv
// Instruction-fetch group buffer. Issues one NW-wide group fetch per accepted
// request, tracks up to OUTST requests in flight, and queues returned groups in
// an in-order DEPTH-entry FIFO. A flush empties the FIFO and converts all
// in-flight requests into responses to be discarded when they return.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   fb            fetch/bus bundle (i_fetch_group_buf_if.slave)
//   stall_cnt     cycles with i_stall=1 (saturating); tied to 0 unless the
//                 macro IFETCH_STALL_CNT_EN is defined
module i_fetch_group_buf #(
    parameter int NW    = 2,
    parameter int DEPTH = 4,
    parameter int OUTST = 2
) (
    input  logic               clk,
    input  logic               resetn,
    i_fetch_group_buf_if.slave fb,
    output logic [31:0]        stall_cnt
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int FAW = $clog2(DEPTH);
    localparam int QAW = (OUTST > 1) ? $clog2(OUTST) : 1;
    // Responses owed to abandoned requests; repeated flushes can stack them,
    // so this is sized well beyond OUTST.
    localparam int DCW = 16;

    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_occ;
    logic [DCW-1:0]    r_drop_cnt;
    logic [31:0]       r_aq [OUTST];
    logic [QAW-1:0]    r_aq_wp;
    logic [QAW-1:0]    r_aq_rp;
    logic [31:0]       r_f_addr [DEPTH];
    logic [32*NW-1:0]  r_f_data [DEPTH];
    logic [NW-1:0]     r_f_ok   [DEPTH];
    logic [FAW-1:0]    r_f_wp;
    logic [FAW-1:0]    r_f_rp;

    logic w_valid, w_credit, w_req, w_acc, w_rsp, w_live, w_push, w_pop, w_stall;

    function automatic logic [QAW-1:0] aq_inc(input logic [QAW-1:0] p);
        return (p == QAW'(OUTST - 1)) ? '0 : p + QAW'(1);
    endfunction

    assign w_valid  = (r_occ != '0);
    // Counting in-flight requests against FIFO space guarantees every live
    // response has a slot waiting for it.
    assign w_credit = (r_inflight < CW'(OUTST)) &&
                      (({1'b0, r_inflight} + {1'b0, r_occ}) < CW1'(DEPTH));
    assign w_req    = fb.fetch_en & ~fb.flush & w_credit;
    assign w_acc    = w_req & fb.inst_addr_ok;
    assign w_rsp    = fb.inst_data_ok[0];
    // Responses return in order, so the oldest drop_cnt beats are the
    // abandoned ones; anything after belongs to the address queue head.
    assign w_live   = w_rsp & (r_drop_cnt == '0);
    assign w_push   = w_live & ~fb.flush;
    assign w_pop    = w_valid & fb.grp_ready;
    assign w_stall  = fb.grp_ready & ~w_valid;

    assign fb.inst_req    = w_req;
    assign fb.fetch_ready = w_acc;
    assign fb.inst_wr     = 1'b0;
    assign fb.inst_size   = 2'b10;
    assign fb.inst_addr   = fb.fetch_addr;
    assign fb.inst_wdata  = '0;
    assign fb.i_stall     = w_stall;
    assign fb.grp_valid   = w_valid;
    assign fb.grp_addr    = w_valid ? r_f_addr[r_f_rp] : '0;
    assign fb.grp_rdata   = w_valid ? r_f_data[r_f_rp] : '0;
    assign fb.grp_ok      = w_valid ? r_f_ok[r_f_rp]   : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inflight <= '0;
            r_occ      <= '0;
            r_drop_cnt <= '0;
            r_aq_wp    <= '0;
            r_aq_rp    <= '0;
            r_f_wp     <= '0;
            r_f_rp     <= '0;
        end else if (fb.flush) begin
            // Everything still owed by the bus, less a beat landing now,
            // will be discarded on return. No accept can happen this cycle.
            r_drop_cnt <= r_drop_cnt + DCW'(r_inflight) - DCW'(w_rsp);
            r_inflight <= '0;
            r_occ      <= '0;
            r_aq_wp    <= '0;
            r_aq_rp    <= '0;
            r_f_wp     <= '0;
            r_f_rp     <= '0;
        end else begin
            if (w_rsp && !w_live) r_drop_cnt <= r_drop_cnt - DCW'(1);
            r_inflight <= r_inflight + CW'(w_acc) - CW'(w_live);
            r_occ      <= r_occ + CW'(w_push) - CW'(w_pop);
            if (w_acc)  r_aq_wp <= aq_inc(r_aq_wp);
            if (w_live) r_aq_rp <= aq_inc(r_aq_rp);
            if (w_push) r_f_wp  <= r_f_wp + FAW'(1);
            if (w_pop)  r_f_rp  <= r_f_rp + FAW'(1);
        end
    end

    // Storage only; validity is carried by the pointers/occupancy above.
    always_ff @(posedge clk) begin
        if (w_acc) r_aq[r_aq_wp] <= fb.fetch_addr;
        if (w_push) begin
            r_f_addr[r_f_wp] <= r_aq[r_aq_rp];
            r_f_data[r_f_wp] <= fb.inst_rdata;
            r_f_ok[r_f_wp]   <= fb.inst_data_ok;
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule
